// File: rtl/tape_player.sv
// Cassette playback: streams tape RAM bytes as framed square-wave cells on `out`, timed by ce_tape ticks.
// Each byte costs 2 clk_sys of fetch; pause freezes all timing; TAPE_LEADER_EN adds a leading '1'-cell tone.
module tape_player #(
  parameter int ADDR_W        = 16,
  parameter int HALF0         = 2,
  parameter int HALF1         = 1,
  parameter int STOP_BITS     = 2,
  parameter int LEADER_CYCLES = 256
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_tape,
  input  logic              loaded,
  input  logic [ADDR_W-1:0] length,
  input  logic              pause,
  input  logic [7:0]        data,
  output logic [ADDR_W-1:0] addr,
  output logic              req,
  output logic              out,
  output logic              done
);

  localparam int FW = 9 + STOP_BITS;
  // One counter serves both bits-per-frame and leader cells remaining.
  localparam int CW = ($clog2(LEADER_CYCLES + 1) > 4) ? $clog2(LEADER_CYCLES + 1) : 4;
  localparam logic [3:0]    H0    = 4'(HALF0);
  localparam logic [3:0]    H1    = 4'(HALF1);
  localparam logic [CW-1:0] NBITS = CW'(FW);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_BIT,
    S_DONE
`ifdef TAPE_LEADER_EN
    , S_LEADER
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [FW-1:0]     sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        tick_q, tick_d, tick_inc, half;
  logic              out_q, out_d;
  logic              req_q, req_d;
  logic              tick, in_cell, cell_end;

  assign tick     = ce_tape & ~pause;
  assign addr_inc = addr_q + ADDR_W'(1);
  assign tick_inc = tick_q + 4'd1;
  assign half     = (state_q == S_BIT && !sr_q[0]) ? H0 : H1;
`ifdef TAPE_LEADER_EN
  assign in_cell  = (state_q == S_BIT) || (state_q == S_LEADER);
`else
  assign in_cell  = (state_q == S_BIT);
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    tick_d   = tick_q;
    out_d    = out_q;
    req_d    = req_q;
    cell_end = 1'b0;

    // out doubles as the half-cell phase: high half first, then low half.
    if (in_cell && tick) begin
      if (tick_inc == half) begin
        tick_d = 4'd0;
        if (out_q) out_d = 1'b0;
        else       cell_end = 1'b1;
      end else begin
        tick_d = tick_inc;
      end
    end

    case (state_q)
      S_IDLE: ;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        sr_d    = {{STOP_BITS{1'b1}}, data, 1'b0};
        cnt_d   = NBITS;
        tick_d  = 4'd0;
        out_d   = 1'b1;
        state_d = S_BIT;
      end
      S_BIT: begin
        if (cell_end) begin
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            if (addr_inc < len_q) begin
              addr_d  = addr_inc;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            out_d = 1'b1;
          end
        end
      end
`ifdef TAPE_LEADER_EN
      S_LEADER: begin
        if (cell_end) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = S_FETCH;
          else              out_d   = 1'b1;
        end
      end
`endif
      S_DONE: begin
        req_d   = 1'b0;
        out_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A load pulse restarts from any state, abandoning the current byte.
    if (loaded) begin
      len_d  = length;
      addr_d = '0;
      req_d  = 1'b1;
      out_d  = 1'b0;
      tick_d = 4'd0;
      cnt_d  = '0;
      if (length == '0) begin
        state_d = S_DONE;
      end else begin
`ifdef TAPE_LEADER_EN
        if (LEADER_CYCLES > 0) begin
          state_d = S_LEADER;
          cnt_d   = CW'(LEADER_CYCLES);
          out_d   = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
`else
        state_d = S_FETCH;
`endif
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      tick_q  <= 4'd0;
      out_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      out_q   <= out_d;
      req_q   <= req_d;
    end
  end

  assign addr = addr_q;
  assign req  = req_q;
  assign out  = out_q;
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player: each tick is sampled before it fires and compared to a hand-built cell waveform.
module tb_tape_player;

`ifdef TAPE_LEADER_EN
  localparam int LEAD_T = 8;
`else
  localparam int LEAD_T = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ce_tape = 1'b0;
  logic        loaded  = 1'b0;
  logic [15:0] length  = 16'd0;
  logic        pause   = 1'b0;
  logic [7:0]  data;
  logic [15:0] addr;
  logic        req, out, done;

  logic [7:0]  mem [0:7];

  int n_checks = 0;
  int n_pass   = 0;

  logic wave_q[$];
  logic exp_q[$];
  int   addr_log[$];
  int   done_at, done_cnt;
  logic req_next;

  always #5 clk_sys = ~clk_sys;

  // Synchronous tape RAM: data follows addr by one clock.
  always @(posedge clk_sys) data <= mem[addr[2:0]];

  tape_player #(
    .ADDR_W(16), .HALF0(2), .HALF1(1), .STOP_BITS(2), .LEADER_CYCLES(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_tape(ce_tape), .loaded(loaded),
    .length(length), .pause(pause), .data(data), .addr(addr),
    .req(req), .out(out), .done(done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic add_cell(input bit b);
    int h;
    h = b ? 1 : 2;
    for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < h; i++) exp_q.push_back(1'b0);
  endtask

  task automatic add_byte(input logic [7:0] v);
    add_cell(1'b0);
    for (int i = 0; i < 8; i++) add_cell(v[i]);
    add_cell(1'b1);
    add_cell(1'b1);
  endtask

  task automatic add_leader();
    for (int i = 0; i < LEAD_T / 2; i++) add_cell(1'b1);
  endtask

  function automatic int wave_errs();
    int e;
    e = (wave_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < wave_q.size() && i < exp_q.size(); i++)
      if (wave_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic start(input int len);
    length = 16'(len);
    loaded = 1'b1;
    cyc(1);
    loaded = 1'b0;
    cyc(3);
  endtask

  // Issue up to max_ticks ticks (4 clocks apart); ticks p_from+1..p_from+p_len are paused.
  task automatic play(input int max_ticks, input int p_from, input int p_len);
    wave_q.delete();
    addr_log.delete();
    done_at  = 0;
    done_cnt = 0;
    req_next = 1'bx;
    for (int t = 1; t <= max_ticks && done_at == 0; t++) begin
      pause = (t > p_from) && (t <= p_from + p_len);
      wave_q.push_back(out);
      addr_log.push_back(int'(addr));
      ce_tape = 1'b1;
      cyc(1);
      ce_tape = 1'b0;
      if (done === 1'b1) begin
        done_at = t;
        done_cnt++;
      end
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        if (k == 0 && done_at != 0) req_next = req;
        if (done === 1'b1) done_cnt++;
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    n_checks++;
    if (addr !== 16'd0) $display("FAIL reset_addr: got %0h expected 0", addr); else n_pass++;
    n_checks++;
    if (req !== 1'b0) $display("FAIL reset_req: got %b expected 0", req); else n_pass++;
    n_checks++;
    if (out !== 1'b0) $display("FAIL reset_out: got %b expected 0", out); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single_byte();
    mem[0] = 8'hA5;
    exp_q.delete();
    add_leader();
    add_byte(8'hA5);
    start(1);
    play(100, 0, 0);
    n_checks++;
    if (done_at != 32 + LEAD_T) $display("FAIL single_done_tick: got %0d expected %0d", done_at, 32 + LEAD_T); else n_pass++;
    n_checks++;
    if (wave_errs() != 0) $display("FAIL single_wave: got %0d bad samples expected 0", wave_errs()); else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++;
    if (req_next !== 1'b0) $display("FAIL single_req_drop: got %b expected 0", req_next); else n_pass++;
  endtask

  task automatic test_zero_length();
    int seen, bad;
    seen = 0;
    bad  = 0;
    length = 16'd0;
    loaded = 1'b1;
    cyc(1);
    loaded = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (done === 1'b1) seen++;
      if (out !== 1'b0 || addr !== 16'd0) bad++;
      cyc(1);
    end
    n_checks++;
    if (seen != 1) $display("FAIL zero_done: got %0d pulses expected 1", seen); else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL zero_out_addr: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++;
    if (req !== 1'b0) $display("FAIL zero_req: got %b expected 0", req); else n_pass++;
  endtask

  task automatic test_multi_byte();
    mem[0] = 8'h00;
    mem[1] = 8'hFF;
    mem[2] = 8'h3C;
    exp_q.delete();
    add_leader();
    add_byte(8'h00);
    add_byte(8'hFF);
    add_byte(8'h3C);
    start(3);
    play(200, 0, 0);
    n_checks++;
    if (done_at != 96 + LEAD_T) $display("FAIL multi_done_tick: got %0d expected %0d", done_at, 96 + LEAD_T); else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL multi_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++;
    if (wave_errs() != 0) $display("FAIL multi_wave: got %0d bad samples expected 0", wave_errs()); else n_pass++;
    n_checks++;
    if (addr_log.size() <= LEAD_T + 64 || addr_log[LEAD_T] != 0 || addr_log[LEAD_T + 40] != 1 || addr_log[LEAD_T + 64] != 2)
      $display("FAIL multi_addr_steps: got %0d entries expected addr 0,1,2 at frame starts", addr_log.size());
    else n_pass++;
    n_checks++;
    if (addr !== 16'd2) $display("FAIL multi_addr_hold: got %0d expected 2", addr); else n_pass++;
  endtask

  task automatic test_pause();
    int p;
    logic u[$];
    p = LEAD_T + 5;
    mem[0] = 8'hA5;
    exp_q.delete();
    add_leader();
    add_byte(8'hA5);
    u = exp_q;
    exp_q.delete();
    for (int t = 1; t <= u.size() + 10; t++) begin
      int idx;
      idx = (t <= p) ? t : ((t <= p + 10) ? p + 1 : t - 10);
      exp_q.push_back(u[idx - 1]);
    end
    start(1);
    play(100, p, 10);
    n_checks++;
    if (done_at != 42 + LEAD_T) $display("FAIL pause_done_tick: got %0d expected %0d", done_at, 42 + LEAD_T); else n_pass++;
    n_checks++;
    if (wave_errs() != 0) $display("FAIL pause_wave: got %0d bad samples expected 0", wave_errs()); else n_pass++;
  endtask

  task automatic test_restart();
    mem[0] = 8'h00;
    mem[1] = 8'hFF;
    mem[2] = 8'h3C;
    start(3);
    play(LEAD_T + 50, 0, 0);
    n_checks++;
    if (done_cnt != 0) $display("FAIL restart_no_done: got %0d pulses expected 0", done_cnt); else n_pass++;
    length = 16'd1;
    loaded = 1'b1;
    cyc(1);
    loaded = 1'b0;
    n_checks++;
    if (addr !== 16'd0) $display("FAIL restart_addr: got %0d expected 0", addr); else n_pass++;
    n_checks++;
    if (req !== 1'b1) $display("FAIL restart_req: got %b expected 1", req); else n_pass++;
    cyc(3);
    exp_q.delete();
    add_leader();
    add_byte(8'h00);
    play(100, 0, 0);
    n_checks++;
    if (done_at != 40 + LEAD_T) $display("FAIL restart_done_tick: got %0d expected %0d", done_at, 40 + LEAD_T); else n_pass++;
    n_checks++;
    if (wave_errs() != 0) $display("FAIL restart_wave: got %0d bad samples expected 0", wave_errs()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start(3);
    play(LEAD_T + 50, 0, 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_checks++;
    if (req !== 1'b0 || out !== 1'b0) $display("FAIL midreset_req_out: got req=%b out=%b expected 0 0", req, out); else n_pass++;
    n_checks++;
    if (addr !== 16'd0) $display("FAIL midreset_addr: got %0d expected 0", addr); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else n_pass++;
    start(2);
    play(10, 0, 0);
    reset  = 1'b1;
    loaded = 1'b1;
    length = 16'd2;
    cyc(1);
    reset  = 1'b0;
    loaded = 1'b0;
    cyc(3);
    n_checks++;
    if (req !== 1'b0) $display("FAIL reset_wins_req: got %b expected 0", req); else n_pass++;
    n_checks++;
    if (out !== 1'b0 || done !== 1'b0) $display("FAIL reset_wins_out: got out=%b done=%b expected 0 0", out, done); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_zero_length();
    test_multi_byte();
    test_pause();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tape_player.md
Name: tape_player

Overview:
- Parametrised cassette playback engine for the Aquarius core. It is the successor to the fixed-format tape block.
- Reads a loaded tape image byte-by-byte from the synchronous tape RAM and serialises each byte as a framed square-wave bit stream on `out`, which drives the PLA `CASS_IN` input.
- Adds configurable address width, bit-cell timing and stop-bit count, plus pause, restart and a completion strobe.
- Timing advances only on `ce_tape` ticks. Memory handshaking runs at `clk_sys` rate.

Parameters:
- ADDR_W, 16, width of tape RAM address and length
- HALF0, 2, `ce_tape` ticks per half-period of a '0' bit cell (1..15)
- HALF1, 1, `ce_tape` ticks per half-period of a '1' bit cell (1..15)
- STOP_BITS, 2, number of '1' stop bits per byte (1..3)
- LEADER_CYCLES, 256, number of '1' bit cells in the leader tone; used only with TAPE_LEADER_EN

Ports:
- clk_sys, in, 1, system clock
- reset, in, 1, synchronous, active-high
- ce_tape, in, 1, tape tick enable; period is at least 4 `clk_sys` cycles
- loaded, in, 1, one-cycle pulse that starts playback from address 0
- length, in, ADDR_W, number of bytes in the image; sampled on `loaded`
- pause, in, 1, freezes playback while high
- data, in, 8, tape RAM read data, valid 1 `clk_sys` after `addr` changes
- addr, out, ADDR_W, tape RAM read address
- req, out, 1, high while playback is active (drives LED and fast-tape clocking)
- out, out, 1, serial cassette level
- done, out, 1, one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values: `addr`=0, `req`=0, `out`=0, `done`=0, state=IDLE, all counters 0.
- States: IDLE, FETCH, LATCH, BIT, DONE.
- IDLE:
  - On `loaded`: latch `length` into `len_q`, set `addr`=0 and `req`=1.
  - If `length`==0, go directly to DONE and never issue a fetch.
  - Otherwise go to FETCH (or LEADER when TAPE_LEADER_EN is defined).
- FETCH: `addr` is stable for one `clk_sys` cycle → go to LATCH.
- LATCH:
  - Shift register ← {`STOP_BITS` ones, `data`, 1'b0}. The start bit goes first and data is sent LSB first.
  - `bit_cnt` = 9+`STOP_BITS` → go to BIT.
  - FETCH and LATCH take 2 `clk_sys` cycles and consume no `ce_tape` ticks. A `ce_tape` tick that falls inside them is ignored.
- BIT:
  - Cell level H = `sr[0]` ? HALF1 : HALF0.
  - `out`=1 for H ticks, then `out`=0 for H ticks. A cell therefore lasts 2H ticks, and a '0' cell lasts 2·HALF0 ticks.
  - At the end of a cell: shift `sr` right and decrement `bit_cnt`.
  - When `bit_cnt` reaches 0:
    - If `addr`+1 < `len_q`: `addr`++ → FETCH.
    - Otherwise → DONE.
- DONE: pulse `done` for 1 `clk_sys`, then `req`=0, `out`=0, `addr` holds → IDLE.
- `pause`=1: `ce_tape` ticks are ignored. `out`, `addr` and all counters hold. `req` stays 1.
- `loaded` asserted in any non-IDLE state restarts from IDLE semantics on the same cycle: new `length`, `addr`=0, current byte abandoned, no `done` pulse.
- `reset` mid-playback: immediate return to the reset values, no `done` pulse.
- `loaded` and `reset` in the same cycle: `reset` wins.
- Address arithmetic is modulo 2^ADDR_W. `length`=2^ADDR_W−1 is the largest playable image.

Optional Feature:
- Macro: TAPE_LEADER_EN
- Defined:
  - After `loaded` with a nonzero length, a LEADER state emits `LEADER_CYCLES` '1' cells (2·HALF1 ticks each) before the first FETCH.
  - `pause` and `restart` apply to LEADER as they do to BIT.
  - `length`=0 skips the leader.
- Undefined: LEADER does not exist and the first FETCH follows `loaded` directly.

Test Plan:
1. Defaults, `length`=1, `data[0]`=0xA5, `loaded` pulse → bit order 0,1,0,1,0,0,1,0,1,1,1; `out` high/low durations are 2/2 for '0' and 1/1 for '1'; `done` fires after exactly 32 `ce_tape` ticks; `req` drops next cycle.
2. `length`=0, `loaded` → `done` within 2 `clk_sys` cycles, `addr` stays 0, `out` stays 0, no `ce_tape` consumed.
3. `length`=3 with bytes 0x00, 0xFF, 0x3C → `addr` steps 0,1,2; frame lengths 40, 24 and 32 ticks; a single `done` after 96 ticks.
4. `pause` held for 10 ticks mid-cell on byte 1 → `out` frozen; total playback extends by exactly 10 ticks; waveform otherwise identical.
5. `loaded` re-pulsed during byte 2 of 3 → no `done`, `addr` returns to 0, playback restarts with the new `length`. Separately, `reset` mid-byte → `req`=`out`=0 and `addr`=0 next cycle.
6. TAPE_LEADER_EN with LEADER_CYCLES=4, `length`=1, 0xA5 → 8 ticks of 1/1 toggling precede the case-1 waveform; `done` after 40 ticks.
